classifier_argmax_stream: RTL and testbench
===========================================

CLASSIFIER_ARGMAX_STREAM -- requirements
Module: classifier_argmax_stream

Interface
REQ-001 SHALL have parameter X_W, default 4: signed feature width.
REQ-002 SHALL have parameter W_W, default 8: signed weight width.
REQ-003 SHALL have parameter ACC_W, default 20: signed accumulator/score width, ACC_W >= X_W+W_W.
REQ-004 SHALL have parameter N_FEAT, default 64: features per class.
REQ-005 SHALL have parameter N_CLASSES, default 8: number of classes, >= 2.
REQ-006 SHALL have parameter CLASS_BITS, default $clog2(N_CLASSES): class index width.
REQ-007 SHALL have port clk  input  1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-009 SHALL have port start  input  1: one-cycle pulse that begins an inference.
REQ-010 SHALL have port in_valid  input  1: x_in/w_in beat valid.
REQ-011 SHALL have port in_ready  output  1: block accepts a beat.
REQ-012 SHALL have port x_in  input  X_W signed: feature value.
REQ-013 SHALL have port w_in  input  W_W signed: weight value.
REQ-014 SHALL have port res_valid  output  1: result available.
REQ-015 SHALL have port res_ready  input  1: consumer takes the result.
REQ-016 SHALL have port res_class  output  CLASS_BITS: winning class index.
REQ-017 SHALL have port res_score  output  ACC_W signed: winning score.
REQ-018 SHALL have port busy  output  1: high in RUN and DONE.
REQ-019 SHALL have port sat_flag  output  1: sticky, set if any accumulation saturated in this inference.

Function
REQ-020 SHALL implement FSM IDLE -> RUN (start in IDLE) -> DONE (final beat accepted) -> IDLE (res_valid && res_ready).
REQ-021 SHALL ignore start outside IDLE.
REQ-022 SHALL drive in_ready = 1 only in RUN; a beat is accepted when in_valid && in_ready.
REQ-023 SHALL order beats feature-major within a class: class 0 features 0..N_FEAT-1, then class 1, and so on; total N_FEAT*N_CLASSES beats.
REQ-024 SHALL form the full-precision product x_in*w_in (X_W+W_W bits), sign-extend it to ACC_W, and add it to the accumulator with saturation to the signed ACC_W range.
REQ-025 SHALL set sat_flag on any clamped add; start clears sat_flag, acc, and both counters.
REQ-026 SHALL, on a class's last feature beat, compare the completed score (including that beat) to best: class 0 always loads; a later class loads only if strictly greater (ties keep the lower index).
REQ-027 SHALL clear acc to 0 in the same cycle as the class-completion compare, so the next beat starts a fresh class with no gap.
REQ-028 SHALL assert res_valid in the cycle after the final accepted beat (latency 1) and hold res_class/res_score/sat_flag stable until the handshake.
REQ-029 SHALL wrap the feature counter at N_FEAT-1 -> 0 and increment the class counter; no beat is accepted after the last class.
REQ-030 SHALL stall with no state change while in_valid is low in RUN.

Reset
REQ-031 SHALL, on rst, go to IDLE and drive in_ready=0, res_valid=0, res_class=0, res_score=0, busy=0, sat_flag=0, clearing counters and acc.
REQ-032 SHALL give rst priority over start and all handshakes; a reset mid-RUN or mid-DONE discards the partial inference.

Structure
REQ-033 SHALL place the FSM state encoding and the saturating-add bound constants in shared package classifier_pkg.
REQ-034 SHALL isolate multiply/sign-extend/saturating-accumulate in sub-module classifier_sat_mac (parametrised X_W, W_W, ACC_W, with a sat output).

Verification (N_FEAT=2, N_CLASSES=3 unless stated)
REQ-035 SHALL check reset: after rst, all outputs 0, FSM IDLE; start while rst is high is ignored.
REQ-036 SHALL check basic argmax: scores 5, 9, -3 (e.g. x=1, w={2,3},{4,5},{-1,-2}) -> res_class=1, res_score=9, sat_flag=0, res_valid one cycle after beat 6.
REQ-037 SHALL check ties: scores 7, 7, 2 -> res_class=0, res_score=7; all-negative scores -4, -1, -9 -> res_class=1, res_score=-1.
REQ-038 SHALL check saturation: ACC_W=12, N_FEAT=4, x=7, w=127 for class 0 -> score 2047, sat_flag=1 held through DONE, cleared by the next start.
REQ-039 SHALL check backpressure: random in_valid gaps give results identical to the gap-free run; res_ready low 5 cycles -> outputs stable and a start pulse in DONE is ignored.
REQ-040 SHALL check reset mid-RUN after beat 3: IDLE next cycle, no res_valid; a fresh inference with scores 1, 2, 3 -> res_class=2.

Source files
------------

// File: rtl/classifier_pkg.sv
// Shared FSM encoding and saturation bounds for the streaming argmax classifier.
package classifier_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Bounds are computed at 64 bits and narrowed by the user, so any ACC_W up to 64 works
   function automatic logic signed [63:0] sat_max(input int acc_w);
      return (64'sd1 <<< (acc_w - 1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_min(input int acc_w);
      return -(64'sd1 <<< (acc_w - 1));
   endfunction

endpackage

// File: rtl/classifier_argmax_stream_if.sv
// Beat input, result output and status signals of the streaming argmax classifier.
interface classifier_argmax_stream_if #(
   parameter int X_W        = 4,
   parameter int W_W        = 8,
   parameter int ACC_W      = 20,
   parameter int CLASS_BITS = 3
);
   logic                    start;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [X_W-1:0]   x_in;
   logic signed [W_W-1:0]   w_in;
   logic                    res_valid;
   logic                    res_ready;
   logic [CLASS_BITS-1:0]   res_class;
   logic signed [ACC_W-1:0] res_score;
   logic                    busy;
   logic                    sat_flag;

   modport slave (
      input  start, in_valid, x_in, w_in, res_ready,
      output in_ready, res_valid, res_class, res_score, busy, sat_flag
   );

   modport master (
      output start, in_valid, x_in, w_in, res_ready,
      input  in_ready, res_valid, res_class, res_score, busy, sat_flag
   );
endinterface

// File: rtl/classifier_sat_mac.sv
// Combinational signed multiply, sign-extend and saturating accumulate.
module classifier_sat_mac
   import classifier_pkg::*;
#(
   parameter int X_W   = 4,
   parameter int W_W   = 8,
   parameter int ACC_W = 20
) (
   input  logic signed [X_W-1:0]   x,
   input  logic signed [W_W-1:0]   w,
   input  logic signed [ACC_W-1:0] acc,
   output logic signed [ACC_W-1:0] acc_next,
   output logic                    sat
);
   localparam int PROD_W = X_W + W_W;
   localparam logic signed [63:0] HI64 = sat_max(ACC_W);
   localparam logic signed [63:0] LO64 = sat_min(ACC_W);
   localparam logic signed [ACC_W-1:0] ACC_HI = HI64[ACC_W-1:0];
   localparam logic signed [ACC_W-1:0] ACC_LO = LO64[ACC_W-1:0];

   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W:0]    sum;

   assign prod = PROD_W'(x) * PROD_W'(w);
   assign sum  = (ACC_W+1)'(acc) + (ACC_W+1)'(prod);

   // One guard bit: overflow iff it disagrees with the ACC_W sign bit; the guard bit is the true sign
   always_comb begin
      sat      = sum[ACC_W] != sum[ACC_W-1];
      acc_next = sum[ACC_W-1:0];
      if (sat) begin
         acc_next = sum[ACC_W] ? ACC_LO : ACC_HI;
      end
   end
endmodule

// File: rtl/classifier_argmax_stream.sv
// Streams feature/weight beats class by class, scores each class with a saturating MAC, reports the argmax.
module classifier_argmax_stream
   import classifier_pkg::*;
#(
   parameter int X_W        = 4,
   parameter int W_W        = 8,
   parameter int ACC_W      = 20,
   parameter int N_FEAT     = 64,
   parameter int N_CLASSES  = 8,
   parameter int CLASS_BITS = $clog2(N_CLASSES)
) (
   input logic                      clk,
   input logic                      rst,
   classifier_argmax_stream_if.slave bus
);
   localparam int FEAT_BITS = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
   localparam logic [FEAT_BITS-1:0]  LAST_FEAT  = FEAT_BITS'(N_FEAT - 1);
   localparam logic [CLASS_BITS-1:0] LAST_CLASS = CLASS_BITS'(N_CLASSES - 1);

   state_t                  state;
   state_t                  state_next;
   logic [FEAT_BITS-1:0]    feat_cnt;
   logic [CLASS_BITS-1:0]   class_cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] acc_next;
   logic signed [ACC_W-1:0] best_score;
   logic [CLASS_BITS-1:0]   best_class;
   logic                    sat_flag;
   logic                    mac_sat;
   logic                    beat;
   logic                    last_feat;
   logic                    last_class;
   logic                    take_best;

   assign beat       = bus.in_valid && (state == ST_RUN);
   assign last_feat  = feat_cnt == LAST_FEAT;
   assign last_class = class_cnt == LAST_CLASS;
   assign take_best  = (class_cnt == '0) || (acc_next > best_score);

   classifier_sat_mac #(
      .X_W   (X_W),
      .W_W   (W_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .x        (bus.x_in),
      .w        (bus.w_in),
      .acc      (acc),
      .acc_next (acc_next),
      .sat      (mac_sat)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next    = state;
      bus.in_ready  = 1'b0;
      bus.res_valid = 1'b0;
      bus.busy      = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (bus.start) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            bus.in_ready = 1'b1;
            bus.busy     = 1'b1;
            if (beat && last_feat && last_class) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            bus.res_valid = 1'b1;
            bus.busy      = 1'b1;
            if (bus.res_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The compare uses acc_next so the class's final beat is part of its score, and acc restarts with no gap
   always_ff @(posedge clk) begin
      if (rst) begin
         feat_cnt   <= '0;
         class_cnt  <= '0;
         acc        <= '0;
         best_score <= '0;
         best_class <= '0;
         sat_flag   <= 1'b0;
      end else if ((state == ST_IDLE) && bus.start) begin
         feat_cnt  <= '0;
         class_cnt <= '0;
         acc       <= '0;
         sat_flag  <= 1'b0;
      end else if (beat) begin
         if (mac_sat) begin
            sat_flag <= 1'b1;
         end
         if (last_feat) begin
            feat_cnt <= '0;
            acc      <= '0;
            if (!last_class) begin
               class_cnt <= class_cnt + CLASS_BITS'(1);
            end
            if (take_best) begin
               best_score <= acc_next;
               best_class <= class_cnt;
            end
         end else begin
            feat_cnt <= feat_cnt + FEAT_BITS'(1);
            acc      <= acc_next;
         end
      end
   end

   assign bus.res_class = best_class;
   assign bus.res_score = best_score;
   assign bus.sat_flag  = sat_flag;
endmodule

// File: tb/tb_classifier_argmax_stream.sv
// Directed, table-driven bench: main instance with N_FEAT=2/N_CLASSES=3, second instance for saturation.
module tb_classifier_argmax_stream;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   classifier_argmax_stream_if #(.X_W(4), .W_W(8), .ACC_W(20), .CLASS_BITS(2)) bus ();
   classifier_argmax_stream_if #(.X_W(4), .W_W(8), .ACC_W(12), .CLASS_BITS(1)) sbus ();

   classifier_argmax_stream #(
      .X_W(4), .W_W(8), .ACC_W(20), .N_FEAT(2), .N_CLASSES(3), .CLASS_BITS(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   classifier_argmax_stream #(
      .X_W(4), .W_W(8), .ACC_W(12), .N_FEAT(4), .N_CLASSES(2), .CLASS_BITS(1)
   ) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (sbus)
   );

   typedef struct {
      string           name;
      logic [0:5][7:0] xv;
      logic [0:5][7:0] wv;
      int              exp_class;
      int              exp_score;
      int              exp_sat;
   } vec_t;

   vec_t vecs[6];

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Start an inference and stream the six beats; optional random in_valid gaps
   task automatic applyStimulus(input vec_t v, input bit gaps);
      int gap;
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int b = 0; b < 6; b++) begin
         if (gaps) begin
            gap = $urandom_range(0, 3);
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
         end
         bus.in_valid = 1'b1;
         bus.x_in     = 4'(v.xv[b]);
         bus.w_in     = v.wv[b];
         checkOutput($sformatf("%s in_ready beat%0d", v.name, b), int'(bus.in_ready), 1);
         checkOutput($sformatf("%s res_valid early beat%0d", v.name, b), int'(bus.res_valid), 0);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic checkResult(input vec_t v);
      checkOutput($sformatf("%s res_valid latency", v.name), int'(bus.res_valid), 1);
      checkOutput($sformatf("%s res_class", v.name), int'(bus.res_class), v.exp_class);
      checkOutput($sformatf("%s res_score", v.name), int'(bus.res_score), v.exp_score);
      checkOutput($sformatf("%s sat_flag", v.name), int'(bus.sat_flag), v.exp_sat);
      checkOutput($sformatf("%s busy in DONE", v.name), int'(bus.busy), 1);
      checkOutput($sformatf("%s in_ready in DONE", v.name), int'(bus.in_ready), 0);
   endtask

   task automatic takeResult(input string name);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      checkOutput($sformatf("%s res_valid after handshake", name), int'(bus.res_valid), 0);
      checkOutput($sformatf("%s busy after handshake", name), int'(bus.busy), 0);
   endtask

   initial begin
      vecs[0] = '{"basic",   {8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1},
                             {8'sd2, 8'sd3, 8'sd4, 8'sd5, -8'sd1, -8'sd2}, 1, 9, 0};
      vecs[1] = '{"tie",     {8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1},
                             {8'sd3, 8'sd4, 8'sd2, 8'sd5, 8'sd1, 8'sd1}, 0, 7, 0};
      vecs[2] = '{"allneg",  {8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1},
                             {-8'sd2, -8'sd2, -8'sd1, 8'sd0, -8'sd4, -8'sd5}, 1, -1, 0};
      vecs[3] = '{"mixed",   {8'sd2, -8'sd3, -8'sd1, 8'sd4, 8'sd3, 8'sd3},
                             {8'sd5, 8'sd1, -8'sd6, 8'sd2, -8'sd2, -8'sd3}, 1, 14, 0};
      vecs[4] = '{"rising",  {8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1},
                             {8'sd1, 8'sd0, 8'sd1, 8'sd1, 8'sd2, 8'sd1}, 2, 3, 0};
      vecs[5] = '{"extreme", {-8'sd8, -8'sd8, 8'sd7, 8'sd7, -8'sd8, 8'sd7},
                             {-8'sd128, -8'sd128, 8'sd127, 8'sd127, -8'sd128, 8'sd127}, 0, 2048, 0};

      rst            = 1'b1;
      bus.start      = 1'b1;
      bus.in_valid   = 1'b0;
      bus.x_in       = '0;
      bus.w_in       = '0;
      bus.res_ready  = 1'b0;
      sbus.start     = 1'b0;
      sbus.in_valid  = 1'b0;
      sbus.x_in      = '0;
      sbus.w_in      = '0;
      sbus.res_ready = 1'b0;

      // Reset with start held high: start must lose
      repeat (3) @(negedge clk);
      checkOutput("reset in_ready", int'(bus.in_ready), 0);
      checkOutput("reset res_valid", int'(bus.res_valid), 0);
      checkOutput("reset res_class", int'(bus.res_class), 0);
      checkOutput("reset res_score", int'(bus.res_score), 0);
      checkOutput("reset busy", int'(bus.busy), 0);
      checkOutput("reset sat_flag", int'(bus.sat_flag), 0);
      checkOutput("reset sat busy", int'(sbus.busy), 0);
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      checkOutput("post-reset busy", int'(bus.busy), 0);
      checkOutput("post-reset in_ready", int'(bus.in_ready), 0);

      for (int g = 0; g < 2; g++) begin
         for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i], g[0]);
            checkResult(vecs[i]);
            takeResult(vecs[i].name);
         end
      end

      // Consumer stalls for five cycles; a start pulse in DONE must be ignored
      applyStimulus(vecs[0], 1'b0);
      checkResult(vecs[0]);
      for (int c = 0; c < 5; c++) begin
         bus.start = (c == 2);
         @(negedge clk);
         bus.start = 1'b0;
         checkOutput($sformatf("stall res_valid c%0d", c), int'(bus.res_valid), 1);
         checkOutput($sformatf("stall res_class c%0d", c), int'(bus.res_class), 1);
         checkOutput($sformatf("stall res_score c%0d", c), int'(bus.res_score), 9);
         checkOutput($sformatf("stall in_ready c%0d", c), int'(bus.in_ready), 0);
      end
      takeResult("stall");

      // Reset after the third accepted beat discards the partial inference
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int b = 0; b < 3; b++) begin
         bus.in_valid = 1'b1;
         bus.x_in     = 4'(vecs[3].xv[b]);
         bus.w_in     = vecs[3].wv[b];
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrun busy", int'(bus.busy), 0);
      checkOutput("midrun in_ready", int'(bus.in_ready), 0);
      checkOutput("midrun res_valid", int'(bus.res_valid), 0);
      checkOutput("midrun res_class", int'(bus.res_class), 0);
      checkOutput("midrun res_score", int'(bus.res_score), 0);
      @(negedge clk);
      checkOutput("midrun res_valid later", int'(bus.res_valid), 0);
      applyStimulus(vecs[4], 1'b0);
      checkResult(vecs[4]);
      takeResult("after midrun reset");

      // Saturation: 4 x (7*127=889) clamps at 2047 in a 12-bit accumulator
      @(negedge clk);
      sbus.start = 1'b1;
      @(negedge clk);
      sbus.start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         sbus.in_valid = 1'b1;
         sbus.x_in     = (b < 4) ? 4'sd7 : 4'sd0;
         sbus.w_in     = (b < 4) ? 8'sd127 : 8'sd0;
         @(negedge clk);
      end
      sbus.in_valid = 1'b0;
      checkOutput("sat res_valid", int'(sbus.res_valid), 1);
      checkOutput("sat res_class", int'(sbus.res_class), 0);
      checkOutput("sat res_score", int'(sbus.res_score), 2047);
      checkOutput("sat sat_flag", int'(sbus.sat_flag), 1);
      repeat (2) begin
         @(negedge clk);
         checkOutput("sat flag held in DONE", int'(sbus.sat_flag), 1);
         checkOutput("sat res_score held", int'(sbus.res_score), 2047);
      end
      sbus.res_ready = 1'b1;
      @(negedge clk);
      sbus.res_ready = 1'b0;
      checkOutput("sat res_valid after handshake", int'(sbus.res_valid), 0);
      checkOutput("sat flag sticky in IDLE", int'(sbus.sat_flag), 1);
      sbus.start = 1'b1;
      @(negedge clk);
      sbus.start = 1'b0;
      checkOutput("sat flag cleared by start", int'(sbus.sat_flag), 0);
      checkOutput("sat busy after start", int'(sbus.busy), 1);
      for (int b = 0; b < 8; b++) begin
         sbus.in_valid = 1'b1;
         sbus.x_in     = 4'sd1;
         sbus.w_in     = 8'sd1;
         @(negedge clk);
      end
      sbus.in_valid = 1'b0;
      checkOutput("sat2 res_valid", int'(sbus.res_valid), 1);
      checkOutput("sat2 res_class tie", int'(sbus.res_class), 0);
      checkOutput("sat2 res_score", int'(sbus.res_score), 4);
      checkOutput("sat2 sat_flag", int'(sbus.sat_flag), 0);
      sbus.res_ready = 1'b1;
      @(negedge clk);
      sbus.res_ready = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
